// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multi-cycle RV32I control FSM with traps and retire pulse
module multicycle_controller #(
  parameter int MEM_TIMEOUT = 16,
  parameter bit EN_SYSTEM   = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic       branch_taken,
  input  logic       imem_ack,
  input  logic       dmem_ack,
  output logic       imem_req,
  output logic       dmem_req,
  output logic       dmem_we,
  output logic       ir_w_en,
  output logic       pc_w_en,
  output logic [1:0] pc_sel,
  output logic       reg_w_en,
  output logic [1:0] reg_w_sel,
  output logic       reg_imm_sel,
  output logic [2:0] imm_sel,
  output logic       rs1_pc_sel,
  output logic       trap,
  output logic [1:0] trap_cause,
  output logic       retire,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_BUS     = 2'b10;
  localparam logic [1:0] CAUSE_ECALL   = 2'b11;

  // Counter only has to reach MEM_TIMEOUT-1: cycle n of a wait is cnt_q == n-1.
  localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    cause_q, cause_d;
  logic          legal;
  logic          timeout_hit;

  assign timeout_hit = (MEM_TIMEOUT != 0) && (cnt_q == CNT_LAST);
  assign state       = rst ? 3'd0 : state_q;
  assign trap_cause  = rst ? 2'b00 : cause_q;

  // Opcode legality; FENCE/SYSTEM exist only when the system extension is enabled.
  always_comb begin
    legal = 1'b0;
    case (opcode)
      OP_LOAD, OP_STORE, OP_REG, OP_IMM, OP_BRANCH,
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR: legal = 1'b1;
      OP_FENCE, OP_SYSTEM:               legal = EN_SYSTEM;
      default:                           legal = 1'b0;
    endcase
  end

  // Next state, wait counter, trap cause and per-phase datapath controls.
  always_comb begin
    state_d     = state_q;
    cause_d     = cause_q;
    cnt_d       = cnt_q + CW'(1);
    imem_req    = 1'b0;
    dmem_req    = 1'b0;
    dmem_we     = 1'b0;
    ir_w_en     = 1'b0;
    pc_w_en     = 1'b0;
    pc_sel      = 2'b00;
    reg_w_en    = 1'b0;
    reg_w_sel   = 2'b00;
    reg_imm_sel = 1'b0;
    imm_sel     = 3'b000;
    rs1_pc_sel  = 1'b0;
    trap        = 1'b0;
    retire      = 1'b0;

    case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_w_en = 1'b1;
          state_d = S_DECODE;
        end else if (timeout_hit) begin
          state_d = S_TRAP;
          cause_d = CAUSE_BUS;
        end
      end
      S_DECODE: begin
        if (legal) begin
          state_d = S_EXEC;
        end else begin
          state_d = S_TRAP;
          cause_d = CAUSE_ILLEGAL;
        end
      end
      S_EXEC: begin
        case (opcode)
          OP_REG, OP_IMM, OP_LUI, OP_AUIPC: state_d = S_WB;
          OP_LOAD, OP_STORE:                state_d = S_MEM;
          OP_BRANCH: begin
            pc_w_en = 1'b1;
            pc_sel  = branch_taken ? 2'b01 : 2'b00;
            retire  = 1'b1;
            state_d = S_FETCH;
          end
          OP_JAL, OP_JALR: begin
            reg_w_en  = 1'b1;
            reg_w_sel = 2'b10;
            pc_w_en   = 1'b1;
            pc_sel    = 2'b01;
            retire    = 1'b1;
            state_d   = S_FETCH;
          end
          OP_FENCE: begin
            pc_w_en = 1'b1;
            retire  = 1'b1;
            state_d = S_FETCH;
          end
          OP_SYSTEM: begin
            state_d = S_TRAP;
            cause_d = CAUSE_ECALL;
          end
          default: state_d = S_FETCH;
        endcase
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (opcode == OP_STORE);
        if (dmem_ack) begin
          if (opcode == OP_STORE) begin
            pc_w_en = 1'b1;
            retire  = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (timeout_hit) begin
          state_d = S_TRAP;
          cause_d = CAUSE_BUS;
        end
      end
      S_WB: begin
        reg_w_en  = 1'b1;
        reg_w_sel = (opcode == OP_LOAD) ? 2'b00 : 2'b01;
        pc_w_en   = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_TRAP: begin
        trap    = 1'b1;
        pc_w_en = 1'b1;
        pc_sel  = 2'b10;
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    // Immediate/operand selects only matter while the datapath is working on the instruction.
    if (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
      reg_imm_sel = !(opcode == OP_REG || opcode == OP_BRANCH);
      case (opcode)
        OP_LOAD, OP_IMM, OP_JALR: imm_sel = 3'b001;
        OP_STORE:                 imm_sel = 3'b011;
        OP_BRANCH:                imm_sel = 3'b100;
        OP_AUIPC: begin
          imm_sel    = 3'b000;
          rs1_pc_sel = 1'b1;
        end
        OP_JAL: begin
          imm_sel    = 3'b010;
          rs1_pc_sel = 1'b1;
        end
        default:                  imm_sel = 3'b000;
      endcase
    end

    // Every wait starts counting from zero when its state is entered.
    if (state_d != state_q) begin
      cnt_d = '0;
    end

    if (rst) begin
      imem_req    = 1'b0;
      dmem_req    = 1'b0;
      dmem_we     = 1'b0;
      ir_w_en     = 1'b0;
      pc_w_en     = 1'b0;
      pc_sel      = 2'b00;
      reg_w_en    = 1'b0;
      reg_w_sel   = 2'b00;
      reg_imm_sel = 1'b0;
      imm_sel     = 3'b000;
      rs1_pc_sel  = 1'b0;
      trap        = 1'b0;
      retire      = 1'b0;
    end
  end

  // State, wait counter and sticky trap cause registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
      cause_q <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - scoreboard bench for multicycle_controller
module tb_multicycle_controller;
  localparam int T = 4;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam int C_ILL = 0, C_ALU = 1, C_LOAD = 2, C_STORE = 3, C_BR = 4,
                 C_JMP = 5, C_FENCE = 6, C_SYS = 7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]      rst_v, bt_v, ia_v, da_v;
  logic [1:0][6:0] op_v;
  logic [1:0]      imem_req_v, dmem_req_v, dmem_we_v, ir_w_en_v, pc_w_en_v;
  logic [1:0]      reg_w_en_v, reg_imm_sel_v, rs1_pc_sel_v, trap_v, retire_v;
  logic [1:0][1:0] pc_sel_v, reg_w_sel_v, trap_cause_v;
  logic [1:0][2:0] imm_sel_v, state_v;

  multicycle_controller #(.MEM_TIMEOUT(T), .EN_SYSTEM(1'b1)) u_dut (
    .clk(clk), .rst(rst_v[0]), .opcode(op_v[0]), .branch_taken(bt_v[0]),
    .imem_ack(ia_v[0]), .dmem_ack(da_v[0]), .imem_req(imem_req_v[0]),
    .dmem_req(dmem_req_v[0]), .dmem_we(dmem_we_v[0]), .ir_w_en(ir_w_en_v[0]),
    .pc_w_en(pc_w_en_v[0]), .pc_sel(pc_sel_v[0]), .reg_w_en(reg_w_en_v[0]),
    .reg_w_sel(reg_w_sel_v[0]), .reg_imm_sel(reg_imm_sel_v[0]), .imm_sel(imm_sel_v[0]),
    .rs1_pc_sel(rs1_pc_sel_v[0]), .trap(trap_v[0]), .trap_cause(trap_cause_v[0]),
    .retire(retire_v[0]), .state(state_v[0])
  );

  multicycle_controller #(.MEM_TIMEOUT(T), .EN_SYSTEM(1'b0)) u_dut_nosys (
    .clk(clk), .rst(rst_v[1]), .opcode(op_v[1]), .branch_taken(bt_v[1]),
    .imem_ack(ia_v[1]), .dmem_ack(da_v[1]), .imem_req(imem_req_v[1]),
    .dmem_req(dmem_req_v[1]), .dmem_we(dmem_we_v[1]), .ir_w_en(ir_w_en_v[1]),
    .pc_w_en(pc_w_en_v[1]), .pc_sel(pc_sel_v[1]), .reg_w_en(reg_w_en_v[1]),
    .reg_w_sel(reg_w_sel_v[1]), .reg_imm_sel(reg_imm_sel_v[1]), .imm_sel(imm_sel_v[1]),
    .rs1_pc_sel(rs1_pc_sel_v[1]), .trap(trap_v[1]), .trap_cause(trap_cause_v[1]),
    .retire(retire_v[1]), .state(state_v[1])
  );

  typedef struct packed {
    int inst;
    int is_trap;
    int cause;
    int lat;
    int pc_sel;
    int rwe;
    int rws;
    int imm;
    int ris;
    int rpc;
    int ndreq;
    int nirw;
    int we;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   last_cause[2];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc[2], ndq[2], nir[2], wev[2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int op_class(input int k, input logic [6:0] op);
    case (op)
      OP_LOAD:                           return C_LOAD;
      OP_STORE:                          return C_STORE;
      OP_REG, OP_IMM, OP_LUI, OP_AUIPC:  return C_ALU;
      OP_BRANCH:                         return C_BR;
      OP_JAL, OP_JALR:                   return C_JMP;
      OP_FENCE:                          return (k == 0) ? C_FENCE : C_ILL;
      OP_SYSTEM:                         return (k == 0) ? C_SYS : C_ILL;
      default:                           return C_ILL;
    endcase
  endfunction

  function automatic logic [6:0] pick_op(input int r);
    case (r)
      0: return OP_LOAD;    1: return OP_STORE;  2: return OP_REG;
      3: return OP_IMM;     4: return OP_BRANCH; 5: return OP_LUI;
      6: return OP_AUIPC;   7: return OP_JAL;    8: return OP_JALR;
      9: return OP_FENCE;   10: return OP_SYSTEM; 11: return 7'b1111111;
      default: return 7'($urandom_range(0, 127));
    endcase
  endfunction

  // ia/da: cycle (1-based) of the wait in which ack arrives; outside 1..T means never.
  task automatic run_instr(input int k, input logic [6:0] op, input int ia, input int da, input bit tk);
    exp_t e;
    int   f, mstart, mlen, cls;
    bit   fetched, mack;
    e = '0;
    e.inst = k;
    fetched = (ia >= 1 && ia <= T);
    f = fetched ? ia : T;
    mstart = 0;
    mlen = 0;
    mack = 1'b0;
    cls = op_class(k, op);
    if (!fetched) begin
      e.is_trap = 1; e.cause = 2; e.lat = T + 1;
    end else begin
      e.nirw = 1;
      case (cls)
        C_ILL: begin e.is_trap = 1; e.cause = 1; e.lat = f + 2; end
        C_SYS: begin e.is_trap = 1; e.cause = 3; e.lat = f + 3; end
        C_ALU: begin e.lat = f + 3; e.rwe = 1; e.rws = 1; end
        C_BR:  begin e.lat = f + 2; e.pc_sel = tk ? 1 : 0; end
        C_JMP: begin e.lat = f + 2; e.rwe = 1; e.rws = 2; e.pc_sel = 1; end
        C_FENCE: e.lat = f + 2;
        default: begin
          mstart = f + 3;
          mack = (da >= 1 && da <= T);
          mlen = mack ? da : T;
          e.ndreq = mlen;
          e.we = (cls == C_STORE) ? 1 : 0;
          if (!mack) begin
            e.is_trap = 1; e.cause = 2; e.lat = f + 2 + T + 1;
          end else if (cls == C_STORE) begin
            e.lat = f + 2 + mlen;
          end else begin
            e.lat = f + 3 + mlen; e.rwe = 1; e.rws = 0;
          end
        end
      endcase
    end
    if (e.is_trap != 0) begin
      e.pc_sel = 2;
      last_cause[k] = e.cause;
    end else begin
      e.cause = last_cause[k];
      e.ris = (op == OP_REG || op == OP_BRANCH) ? 0 : 1;
      case (op)
        OP_LOAD, OP_IMM, OP_JALR: e.imm = 1;
        OP_STORE:  e.imm = 3;
        OP_BRANCH: e.imm = 4;
        OP_JAL:    begin e.imm = 2; e.rpc = 1; end
        OP_AUIPC:  e.rpc = 1;
        default:   e.imm = 0;
      endcase
    end
    exp_q.push_back(e);
    for (int c = 1; c <= e.lat; c++) begin
      op_v[k] = op;
      if (c <= f) ia_v[k] = fetched && (c == f);
      else        ia_v[k] = ($urandom % 4 == 0);
      if (mlen > 0 && c >= mstart && c < mstart + mlen) da_v[k] = mack && (c == mstart + mlen - 1);
      else                                              da_v[k] = ($urandom % 4 == 0);
      bt_v[k] = (c == f + 2) ? tk : ($urandom % 2 == 1);
      @(posedge clk); #1;
    end
    ia_v[k] = 1'b0;
    da_v[k] = 1'b0;
  endtask

  // Start a load, abandon it in MEM with a one-cycle reset: nothing may retire or trap.
  task automatic abort_instr(input int k, input int ncyc);
    for (int c = 1; c <= ncyc; c++) begin
      op_v[k] = OP_LOAD;
      ia_v[k] = (c == 1);
      da_v[k] = 1'b0;
      bt_v[k] = 1'b0;
      @(posedge clk); #1;
    end
    rst_v[k] = 1'b1;
    ia_v[k] = 1'b1;
    da_v[k] = 1'b1;
    @(posedge clk); #1;
    rst_v[k] = 1'b0;
    ia_v[k] = 1'b0;
    da_v[k] = 1'b0;
    last_cause[k] = 0;
  endtask

  // Monitor: reset-quiet outputs, and one scoreboard pop per retire/trap pulse.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst_v[k]) begin
        chk($sformatf("rst_outputs_zero%0d", k),
            32'({imem_req_v[k], dmem_req_v[k], dmem_we_v[k], ir_w_en_v[k], pc_w_en_v[k],
                 pc_sel_v[k], reg_w_en_v[k], reg_w_sel_v[k], reg_imm_sel_v[k], imm_sel_v[k],
                 rs1_pc_sel_v[k], trap_v[k], trap_cause_v[k], retire_v[k], state_v[k]}), 32'd0);
        cyc[k] = 0; ndq[k] = 0; nir[k] = 0; wev[k] = 0;
      end else begin
        cyc[k]++;
        if (dmem_req_v[k] === 1'b1) begin
          ndq[k]++;
          if (dmem_we_v[k] === 1'b1) wev[k] = 1;
        end
        if (ir_w_en_v[k] === 1'b1) nir[k]++;
        if (retire_v[k] === 1'b1 || trap_v[k] === 1'b1) begin
          chk("retire_trap_exclusive", 32'(retire_v[k] & trap_v[k]), 32'd0);
          if (exp_q.size() == 0) begin
            chk("unexpected_event", 32'(exp_q.size()), 32'd1);
          end else begin
            mon_e = exp_q.pop_front();
            chk("event_instance", k, mon_e.inst);
            chk("is_trap", 32'(trap_v[k]), mon_e.is_trap);
            chk("latency", cyc[k], mon_e.lat);
            chk("trap_cause", 32'(trap_cause_v[k]), mon_e.cause);
            chk("pc_sel", 32'(pc_sel_v[k]), mon_e.pc_sel);
            chk("pc_w_en", 32'(pc_w_en_v[k]), 32'd1);
            chk("reg_w_en", 32'(reg_w_en_v[k]), mon_e.rwe);
            chk("reg_w_sel", 32'(reg_w_sel_v[k]), mon_e.rws);
            chk("imm_sel", 32'(imm_sel_v[k]), mon_e.imm);
            chk("reg_imm_sel", 32'(reg_imm_sel_v[k]), mon_e.ris);
            chk("rs1_pc_sel", 32'(rs1_pc_sel_v[k]), mon_e.rpc);
            chk("dmem_req_cycles", ndq[k], mon_e.ndreq);
            chk("ir_w_en_count", nir[k], mon_e.nirw);
            chk("dmem_we", wev[k], mon_e.we);
          end
          cyc[k] = 0; ndq[k] = 0; nir[k] = 0; wev[k] = 0;
        end
      end
    end
  end

  initial begin
    rst_v = 2'b11;
    ia_v = '0; da_v = '0; bt_v = '0; op_v = '0;
    last_cause[0] = 0;
    last_cause[1] = 0;
    for (int k = 0; k < 2; k++) begin
      cyc[k] = 0; ndq[k] = 0; nir[k] = 0; wev[k] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    rst_v[0] = 1'b0;

    run_instr(0, OP_REG,    1, 0, 1'b0);
    run_instr(0, OP_LOAD,   1, 3, 1'b0);
    run_instr(0, OP_BRANCH, 1, 0, 1'b1);
    run_instr(0, OP_BRANCH, 2, 0, 1'b0);
    run_instr(0, 7'b1111111, 1, 0, 1'b0);
    run_instr(0, OP_STORE,  1, 0, 1'b0);
    run_instr(0, OP_STORE,  1, T, 1'b0);
    run_instr(0, OP_SYSTEM, 1, 0, 1'b0);
    run_instr(0, OP_FENCE,  1, 0, 1'b0);
    run_instr(0, OP_JAL,    3, 0, 1'b0);
    run_instr(0, OP_JALR,   T, 0, 1'b0);
    run_instr(0, OP_AUIPC,  2, 0, 1'b0);
    run_instr(0, OP_LUI,    0, 0, 1'b0);
    abort_instr(0, 4);
    run_instr(0, OP_IMM,    1, 0, 1'b0);

    for (int i = 0; i < 300; i++) begin
      run_instr(0, pick_op($urandom % 14),
                ($urandom % 8 == 0) ? 0 : int'($urandom_range(1, T)),
                ($urandom % 8 == 0) ? 0 : int'($urandom_range(1, T)),
                1'($urandom % 2));
    end

    rst_v[0] = 1'b1;
    rst_v[1] = 1'b0;
    run_instr(1, OP_SYSTEM, 1, 0, 1'b0);
    run_instr(1, OP_FENCE,  2, 0, 1'b0);
    run_instr(1, OP_REG,    1, 0, 1'b0);
    for (int i = 0; i < 80; i++) begin
      run_instr(1, pick_op($urandom % 14),
                ($urandom % 8 == 0) ? 0 : int'($urandom_range(1, T)),
                ($urandom % 8 == 0) ? 0 : int'($urandom_range(1, T)),
                1'($urandom % 2));
    end
    rst_v[1] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Multi-cycle successor to the single-cycle opcode decoder for the RV32I core. A state machine sequences every instruction through fetch, decode, execute, memory and write-back phases over a ready/ack memory interface. It produces all datapath enables and selects per phase, adds traps for illegal opcodes, environment calls and memory timeouts, and emits a retire pulse per completed instruction. It sits between the instruction register/datapath and the instruction and data memory ports.

## Interface
- MEM_TIMEOUT, 16, max cycles a FETCH or MEM access waits for ack before a bus-timeout trap; 0 disables the timeout
- EN_SYSTEM, 1, 1: FENCE is a no-op and SYSTEM raises an ecall trap; 0: both are illegal
- clk  input  1  clock; one clock domain
- rst  input  1  synchronous, active-high reset
- opcode  input  7  instr[6:0] from the instruction register
- branch_taken  input  1  ALU compare result, sampled in EXEC
- imem_ack  input  1  instruction memory has data this cycle
- dmem_ack  input  1  data access completes this cycle
- imem_req  output  1  instruction fetch request
- dmem_req  output  1  data access request
- dmem_we  output  1  0: load, 1: store
- ir_w_en  output  1  latch the instruction register
- pc_w_en  output  1  update the PC
- pc_sel  output  2  00: pc+4, 01: branch/jump target, 10: trap vector
- reg_w_en  output  1  register file write
- reg_w_sel  output  2  00: dmem, 01: alu, 10: pc+4
- reg_imm_sel  output  1  0: rs2, 1: imm
- imm_sel  output  3  000: U, 001: I, 010: J, 011: S, 100: B
- rs1_pc_sel  output  1  0: rs1, 1: pc
- trap  output  1  one-cycle pulse on trap entry
- trap_cause  output  2  01: illegal, 10: bus timeout, 11: ecall; registered, holds until the next trap
- retire  output  1  one-cycle pulse when an instruction completes
- state  output  3  current state, for debug

## Operation
- State encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5. Codes 6 and 7 go to FETCH.
- Reset: state=FETCH and trap_cause=00. While rst=1, every output is 0.
- FETCH: imem_req=1. On imem_ack, ir_w_en=1 in the same cycle and the next state is DECODE.
- DECODE: all enables are 0.
  - Legal opcodes: 0000011 load, 0100011 store, 0110011 reg-reg, 0010011 reg-imm, 1100011 branch, 0110111 lui, 0010111 auipc, 1101111 jal, 1100111 jalr, plus 0001111/1110011 when EN_SYSTEM=1.
  - Legal opcode: next state is EXEC. Any other opcode: next state is TRAP with cause 01.
- EXEC, by opcode:
  - reg-reg, reg-imm, lui, auipc: next state is WB.
  - load, store: next state is MEM.
  - branch: pc_w_en=1; pc_sel=01 if branch_taken, else 00; retire=1; next state is FETCH.
  - jal, jalr: reg_w_en=1, reg_w_sel=10, pc_w_en=1, pc_sel=01, retire=1; next state is FETCH.
  - fence: pc_w_en=1, pc_sel=00, retire=1; next state is FETCH.
  - system: next state is TRAP with cause 11.
- MEM: dmem_req=1, dmem_we=(opcode==store). On dmem_ack:
  - store: pc_w_en=1, pc_sel=00, retire=1; next state is FETCH.
  - load: next state is WB.
- WB: reg_w_en=1, reg_w_sel=00 for load and 01 otherwise; pc_w_en=1, pc_sel=00, retire=1; next state is FETCH.
- TRAP: trap=1, pc_w_en=1, pc_sel=10; trap_cause is updated; retire=0; next state is FETCH.
- Decode fields are driven in EXEC, MEM and WB only, and are 0 in other states:
  - load, reg-imm, jalr: imm I.
  - store: imm S.
  - branch: imm B.
  - lui, auipc: imm U; auipc also sets rs1_pc_sel=1.
  - jal: imm J, rs1_pc_sel=1.
  - reg_imm_sel=1 for every opcode except reg-reg and branch.

## Timing
- Wait counter:
  - Cleared on entry to FETCH and MEM; counts cycles spent in the state.
  - An ack in cycles 1..MEM_TIMEOUT is accepted.
  - No ack by cycle MEM_TIMEOUT: next state is TRAP with cause 10.
  - Ack in the same cycle as timeout: the ack wins.
- Latency with ack in the first cycle: ALU op and store 4 cycles; load 5; branch, jal and fence 3; illegal opcode 3 (including TRAP).
- Acks are ignored outside their own state (imem_ack outside FETCH, dmem_ack outside MEM).
- rst asserted mid-instruction: the next state is FETCH with no retire and no trap.
- retire and trap are never high in the same cycle.

## Test plan
- Reset, then reg-reg (0110011) with imem_ack in the first cycle -> states 0,1,2,4,0; reg_w_en=1 and reg_w_sel=01 in WB; one retire pulse, 4 cycles after FETCH entry.
- Load (0000011) with dmem_ack after 3 cycles -> dmem_req high for 3 cycles with dmem_we=0; WB has reg_w_sel=00; total 7 cycles.
- Branch (1100011) with branch_taken=1, then again with branch_taken=0 -> pc_sel=01 then 00 in EXEC; imm_sel=100; reg_imm_sel=0.
- Opcode 1111111 -> TRAP in the cycle after DECODE; trap=1, trap_cause=01, pc_sel=10; no retire.
- MEM_TIMEOUT=4, store with dmem_ack never asserted -> 4 MEM cycles, then TRAP with trap_cause=10. Repeat with ack in cycle 4 -> store retires normally.
- EN_SYSTEM=0 with opcode 1110011 -> trap_cause=01. EN_SYSTEM=1 -> trap_cause=11. EN_SYSTEM=1 with opcode 0001111 -> retire, pc_sel=00.
